ptp_ts_fifo_wr_arb: RTL

//  Write-side controller for the 128-bit PTP timestamp dcfifo (16 words). Two timestamp sources (src0 = TX egress,
//  src1 = RX ingress) share the FIFO write port via a one-entry holding register per source and round-robin grants.

---
 rtl/ptp_ts_pkg.sv | 19 +
 rtl/ptp_ts_hold_reg.sv | 76 +++++++
 rtl/ptp_ts_fifo_wr_arb.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ptp_ts_pkg.sv
// Shared definitions for the PTP timestamp FIFO write path.
//  - record / payload widths and the source ID tags placed in fifo_data[127:126]
//  - write-controller FSM state encoding
package ptp_ts_pkg;

  localparam int TS_REC_W     = 128;
  localparam int TS_PAYLOAD_W = 126;
  localparam int DROP_CNT_W   = 16;

  localparam logic [1:0] SRC_ID_TX = 2'b00;  // src0, TX egress
  localparam logic [1:0] SRC_ID_RX = 2'b01;  // src1, RX ingress

  typedef enum logic [1:0] {
    CLR    = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ptp_ts_hold_reg.sv
// One-entry holding register for a timestamp source, plus its saturating
// drop counter.
//  clk, reset_n  clock, asynchronous active-low reset
//  flush         empties the register and clears the drop counter
//  accept_en     low while the FIFO clear is running; beats are ignored then
//  src_valid/src_data/src_ready  source handshake
//  grant         arbiter takes the held record this cycle
//  full/data     register contents seen by the arbiter
//  drop_cnt      records discarded because the register was occupied
//
// Handshake: a beat transfers on a rising clk edge where src_valid and
// src_ready are both high; src_valid/src_data must stay stable until then.
module ptp_ts_hold_reg
  import ptp_ts_pkg::*;
#(
  parameter bit DROP_ON_FULL = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    accept_en,
  input  logic                    src_valid,
  input  logic [TS_PAYLOAD_W-1:0] src_data,
  output logic                    src_ready,
  input  logic                    grant,
  output logic                    full,
  output logic [TS_PAYLOAD_W-1:0] data,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  logic                    full_q, full_d;
  logic [TS_PAYLOAD_W-1:0] data_q, data_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                    hold_room;
  logic                    load;
  logic                    drop;

  always_comb begin
    // A register being granted this cycle can take a new beat in the same cycle.
    hold_room = !full_q || grant;
    if (DROP_ON_FULL) src_ready = 1'b1;
    else              src_ready = hold_room && accept_en;
    load = src_valid && src_ready && accept_en && hold_room && !flush;
    drop = DROP_ON_FULL && src_valid && accept_en && !hold_room;

    full_d     = full_q;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      full_d     = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (load)       full_d = 1'b1;
      else if (grant) full_d = 1'b0;
      if (load) data_d = src_data;
      if (drop && (drop_cnt_q != {DROP_CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q     <= 1'b0;
      data_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      full_q     <= full_d;
      data_q     <= data_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign full     = full_q;
  assign data     = data_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: rtl/ptp_ts_fifo_wr_arb.sv
// Write-side controller for the 16-word, 128-bit PTP timestamp dcfifo.
// Two sources share the FIFO write port through one holding register each and
// a round-robin arbiter; each record is tagged with its source ID. The block
// also sequences the FIFO aclr (CLR -> SETTLE -> RUN) after reset / soft clear.
//  clk, reset_n            FIFO wrclk, asynchronous active-low reset
//  soft_clr                rerun the clear sequence (only honoured in RUN)
//  srcN_valid/data/ready   source handshakes (N = 0 TX, 1 RX)
//  fifo_data, fifo_wrreq   registered FIFO write port {src_id, payload}
//  fifo_wrfull, fifo_wrusedw  FIFO write-side status
//  fifo_aclr               registered FIFO asynchronous clear
//  drop_cnt0/1             saturating dropped-record counters
//  busy                    clear sequence in progress (CLR or SETTLE)
module ptp_ts_fifo_wr_arb
  import ptp_ts_pkg::*;
#(
  parameter int AFULL_LVL     = 14,
  parameter int CLR_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter bit DROP_ON_FULL  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    soft_clr,
  input  logic                    src0_valid,
  input  logic [TS_PAYLOAD_W-1:0] src0_data,
  output logic                    src0_ready,
  input  logic                    src1_valid,
  input  logic [TS_PAYLOAD_W-1:0] src1_data,
  output logic                    src1_ready,
  output logic [TS_REC_W-1:0]     fifo_data,
  output logic                    fifo_wrreq,
  input  logic                    fifo_wrfull,
  input  logic [3:0]              fifo_wrusedw,
  output logic                    fifo_aclr,
  output logic [DROP_CNT_W-1:0]   drop_cnt0,
  output logic [DROP_CNT_W-1:0]   drop_cnt1,
  output logic                    busy
);

  localparam logic [7:0] CLR_LAST    = 8'(CLR_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [4:0] AFULL_W     = 5'(AFULL_LVL);

  ts_state_e             state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rr_q, rr_d;          // last granted source
  logic                  wrreq_q, wrreq_d;
  logic [TS_REC_W-1:0]   data_q, data_d;
  logic                  aclr_q, aclr_d;
  logic                  busy_q, busy_d;

  logic                    flush, accept_en, room, gnt0, gnt1;
  logic                    full0, full1;
  logic [TS_PAYLOAD_W-1:0] hold0, hold1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = (state_q == RUN) && soft_clr;
    unique case (state_q)
      CLR: begin
        if (cnt_q == CLR_LAST) begin state_d = SETTLE; cnt_d = '0; end
        else cnt_d = cnt_q + 8'd1;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin state_d = RUN; cnt_d = '0; end
        else cnt_d = cnt_q + 8'd1;
      end
      RUN: begin
        if (soft_clr) begin state_d = CLR; cnt_d = '0; end
      end
      default: begin state_d = CLR; cnt_d = '0; end
    endcase

    accept_en = (state_q != CLR);
    // wrusedw lags wrreq by a cycle, so one extra write can slip in past AFULL_LVL.
    // No grant in the soft_clr cycle: its write would land while aclr is high.
    room = (state_q == RUN) && !soft_clr && !fifo_wrfull &&
           ({1'b0, fifo_wrusedw} < AFULL_W);

    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (room) begin
      if (full0 && full1) begin
        if (rr_q) gnt0 = 1'b1;
        else      gnt1 = 1'b1;
      end else if (full0) begin
        gnt0 = 1'b1;
      end else if (full1) begin
        gnt1 = 1'b1;
      end
    end

    rr_d = rr_q;
    if (gnt0) rr_d = 1'b0;
    if (gnt1) rr_d = 1'b1;

    wrreq_d = gnt0 || gnt1;
    data_d  = data_q;
    if (gnt0)      data_d = {SRC_ID_TX, hold0};
    else if (gnt1) data_d = {SRC_ID_RX, hold1};

    aclr_d = (state_d == CLR);
    busy_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLR;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      wrreq_q <= 1'b0;
      data_q  <= '0;
      aclr_q  <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
      aclr_q  <= aclr_d;
      busy_q  <= busy_d;
    end
  end

  ptp_ts_hold_reg #(.DROP_ON_FULL(DROP_ON_FULL)) u_hold0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .accept_en(accept_en),
    .src_valid(src0_valid), .src_data(src0_data), .src_ready(src0_ready),
    .grant(gnt0), .full(full0), .data(hold0), .drop_cnt(drop_cnt0)
  );

  ptp_ts_hold_reg #(.DROP_ON_FULL(DROP_ON_FULL)) u_hold1 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .accept_en(accept_en),
    .src_valid(src1_valid), .src_data(src1_data), .src_ready(src1_ready),
    .grant(gnt1), .full(full1), .data(hold1), .drop_cnt(drop_cnt1)
  );

  assign fifo_data  = data_q;
  assign fifo_wrreq = wrreq_q;
  assign fifo_aclr  = aclr_q;
  assign busy       = busy_q;

endmodule
